// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall control for a 5-stage pipeline with Decode branch
// resolution, multi-cycle data memory wait/timeout FSM and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic              branch_d,
  input  logic              redirect_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic              memaccess_m,
  input  logic              dm_ready,
  input  logic [REG_AW-1:0] writereg_w,
  input  logic              regwrite_w,
  input  logic              clr_cnt,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              bubble_w,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  memwait_cnt,
  output logic              mem_timeout,
  output logic [1:0]        state
);

  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0]   memwait_cnt_q, memwait_cnt_d;

  logic lwstall, brstall, memstall, hz, halted;

  // Register equality that never fires on a hardwired zero register.
  function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (regwrite_m && match(writereg_m, rs_e))      forward_a_e = 2'b10;
    else if (regwrite_w && match(writereg_w, rs_e)) forward_a_e = 2'b01;
    if (regwrite_m && match(writereg_m, rt_e))      forward_b_e = 2'b10;
    else if (regwrite_w && match(writereg_w, rt_e)) forward_b_e = 2'b01;
    forward_a_d = regwrite_m && match(writereg_m, rs_d);
    forward_b_d = regwrite_m && match(writereg_m, rt_d);
  end

  always_comb begin
    lwstall  = memtoreg_e && regwrite_e &&
               ((uses_rs_d && match(writereg_e, rs_d)) || (uses_rt_d && match(writereg_e, rt_d)));
    brstall  = branch_d &&
               ((regwrite_e && (match(writereg_e, rs_d) || match(writereg_e, rt_d))) ||
                (memtoreg_m && (match(writereg_m, rs_d) || match(writereg_m, rt_d))));
    memstall = memaccess_m && !dm_ready;
    hz       = lwstall || brstall;
    halted   = (state_q == ST_HALT);
  end

  // Stall/flush priority: halt, memory wait, data hazard, then branch redirect.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    if (halted || memstall) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (hz) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      flush_d = redirect_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dm_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
          state_d       = ST_HALT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating counters; clear wins over increment.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    memwait_cnt_d  = memwait_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d    = '0;
      redirect_cnt_d = '0;
      memwait_cnt_d  = '0;
    end else begin
      if (hz && !memstall && !halted && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_d && (redirect_cnt_q != {CNT_W{1'b1}}))
        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      if (memstall && !halted && (memwait_cnt_q != {CNT_W{1'b1}}))
        memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      memwait_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      memwait_cnt_q  <= memwait_cnt_d;
    end
  end

  assign state        = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
  assign memwait_cnt  = memwait_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table through a scoreboard queue,
// plus hand sequences for memory wait, timeout/halt, reset and counter saturation.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       uses_rs_d;
    logic       uses_rt_d;
    logic       branch_d;
    logic       redirect_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] writereg_e;
    logic       regwrite_e;
    logic       memtoreg_e;
    logic [4:0] writereg_m;
    logic       regwrite_m;
    logic       memtoreg_m;
    logic       memaccess_m;
    logic       dm_ready;
    logic [4:0] writereg_w;
    logic       regwrite_w;
  } in_t;

  typedef struct packed {
    logic       sf, sd, se, sm, fd, fe, bw, fad, fbd;
    logic [1:0] fae, fbe;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr_cnt = 1'b0;
  in_t  vin = '0;

  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w;
  logic       forward_a_d, forward_b_d, mem_timeout;
  logic [1:0] forward_a_e, forward_b_e, state;
  logic [3:0] stall_cnt, redirect_cnt, memwait_cnt;

  logic       nz_sf, nz_sd, nz_se, nz_sm, nz_fd, nz_fe, nz_bw, nz_fad, nz_fbd, nz_mt;
  logic [1:0] nz_fae, nz_fbe, nz_state;
  logic [3:0] nz_sc, nz_rc, nz_mc;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b1), .CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .rs_d(vin.rs_d), .rt_d(vin.rt_d), .uses_rs_d(vin.uses_rs_d), .uses_rt_d(vin.uses_rt_d),
    .branch_d(vin.branch_d), .redirect_d(vin.redirect_d),
    .rs_e(vin.rs_e), .rt_e(vin.rt_e), .writereg_e(vin.writereg_e),
    .regwrite_e(vin.regwrite_e), .memtoreg_e(vin.memtoreg_e),
    .writereg_m(vin.writereg_m), .regwrite_m(vin.regwrite_m), .memtoreg_m(vin.memtoreg_m),
    .memaccess_m(vin.memaccess_m), .dm_ready(vin.dm_ready),
    .writereg_w(vin.writereg_w), .regwrite_w(vin.regwrite_w), .clr_cnt(clr_cnt),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .bubble_w(bubble_w),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .memwait_cnt(memwait_cnt),
    .mem_timeout(mem_timeout), .state(state)
  );

  // Same inputs, register 0 treated as an ordinary register.
  pipe_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b0), .CNT_W(4), .TIMEOUT(4)) dut_nz (
    .clk(clk), .reset(reset),
    .rs_d(vin.rs_d), .rt_d(vin.rt_d), .uses_rs_d(vin.uses_rs_d), .uses_rt_d(vin.uses_rt_d),
    .branch_d(vin.branch_d), .redirect_d(vin.redirect_d),
    .rs_e(vin.rs_e), .rt_e(vin.rt_e), .writereg_e(vin.writereg_e),
    .regwrite_e(vin.regwrite_e), .memtoreg_e(vin.memtoreg_e),
    .writereg_m(vin.writereg_m), .regwrite_m(vin.regwrite_m), .memtoreg_m(vin.memtoreg_m),
    .memaccess_m(vin.memaccess_m), .dm_ready(vin.dm_ready),
    .writereg_w(vin.writereg_w), .regwrite_w(vin.regwrite_w), .clr_cnt(clr_cnt),
    .stall_f(nz_sf), .stall_d(nz_sd), .stall_e(nz_se), .stall_m(nz_sm),
    .flush_d(nz_fd), .flush_e(nz_fe), .bubble_w(nz_bw),
    .forward_a_d(nz_fad), .forward_b_d(nz_fbd),
    .forward_a_e(nz_fae), .forward_b_e(nz_fbe),
    .stall_cnt(nz_sc), .redirect_cnt(nz_rc), .memwait_cnt(nz_mc),
    .mem_timeout(nz_mt), .state(nz_state)
  );

  function automatic exp_t get_act();
    exp_t a;
    a.sf = stall_f;  a.sd = stall_d;  a.se = stall_e;  a.sm = stall_m;
    a.fd = flush_d;  a.fe = flush_e;  a.bw = bubble_w;
    a.fad = forward_a_d;  a.fbd = forward_b_d;
    a.fae = forward_a_e;  a.fbe = forward_b_e;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    vin = '0;
    clr_cnt = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{i: '0, e: '0};
    tbl[1]  = '{i: '{regwrite_m: 1'b1, writereg_m: 5'd8, regwrite_w: 1'b1, writereg_w: 5'd8,
                     rs_e: 5'd8, default: '0}, e: '{fae: 2'b10, default: '0}};
    tbl[2]  = '{i: '{regwrite_m: 1'b1, writereg_m: 5'd9, regwrite_w: 1'b1, writereg_w: 5'd8,
                     rs_e: 5'd8, default: '0}, e: '{fae: 2'b01, default: '0}};
    tbl[3]  = '{i: '{regwrite_m: 1'b1, regwrite_w: 1'b1, default: '0}, e: '0};
    tbl[4]  = '{i: '{regwrite_w: 1'b1, writereg_w: 5'd7, rt_e: 5'd7, default: '0},
                e: '{fbe: 2'b01, default: '0}};
    tbl[5]  = '{i: '{regwrite_m: 1'b1, writereg_m: 5'd7, regwrite_w: 1'b1, writereg_w: 5'd7,
                     rt_e: 5'd7, rt_d: 5'd7, default: '0}, e: '{fbe: 2'b10, fbd: 1'b1, default: '0}};
    tbl[6]  = '{i: '{writereg_m: 5'd7, writereg_w: 5'd7, rt_e: 5'd7, rt_d: 5'd7, default: '0},
                e: '0};
    tbl[7]  = '{i: '{memtoreg_e: 1'b1, regwrite_e: 1'b1, writereg_e: 5'd5, uses_rt_d: 1'b1,
                     rt_d: 5'd5, redirect_d: 1'b1, default: '0},
                e: '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0}};
    tbl[8]  = '{i: '{memtoreg_e: 1'b1, regwrite_e: 1'b1, writereg_e: 5'd5, rt_d: 5'd5,
                     redirect_d: 1'b1, default: '0}, e: '{fd: 1'b1, default: '0}};
    tbl[9]  = '{i: '{memtoreg_e: 1'b1, regwrite_e: 1'b1, uses_rs_d: 1'b1, default: '0}, e: '0};
    tbl[10] = '{i: '{branch_d: 1'b1, rs_d: 5'd3, memtoreg_m: 1'b1, writereg_m: 5'd3, default: '0},
                e: '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0}};
    tbl[11] = '{i: '{branch_d: 1'b1, rs_d: 5'd3, regwrite_m: 1'b1, writereg_m: 5'd3, default: '0},
                e: '{fad: 1'b1, default: '0}};
    tbl[12] = '{i: '{branch_d: 1'b1, rt_d: 5'd4, regwrite_e: 1'b1, writereg_e: 5'd4, default: '0},
                e: '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0}};
    tbl[13] = '{i: '{memtoreg_e: 1'b1, writereg_e: 5'd5, uses_rt_d: 1'b1, rt_d: 5'd5, default: '0},
                e: '0};
    tbl[14] = '{i: '{memaccess_m: 1'b1, dm_ready: 1'b1, redirect_d: 1'b1, default: '0},
                e: '{fd: 1'b1, default: '0}};
    tbl[15] = '{i: '{memaccess_m: 1'b1, memtoreg_e: 1'b1, regwrite_e: 1'b1, writereg_e: 5'd5,
                     uses_rt_d: 1'b1, rt_d: 5'd5, redirect_d: 1'b1, default: '0},
                e: '{sf: 1'b1, sd: 1'b1, se: 1'b1, sm: 1'b1, bw: 1'b1, default: '0}};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_outputs", 32'(get_act()), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_counters", {20'd0, stall_cnt, redirect_cnt, memwait_cnt}, 32'd0);

    // Vector table through the scoreboard, one vector per cycle
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1 vin = tbl[k].i;
      sb_q.push_back(tbl[k].e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty vec=%0d", k);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("vec%0d", k), 32'(get_act()), 32'(e));
      end
    end
    @(posedge clk);
    #1 vin = '0;
    chk("tbl_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("tbl_redirect_cnt", 32'(redirect_cnt), 32'd2);
    chk("tbl_memwait_cnt", 32'(memwait_cnt), 32'd1);
    chk("tbl_state_wait", 32'(state), 32'd1);
    reset = 1'b1;
    #1 chk("reset_mid_wait", 32'(state), 32'd0);

    // Zero register is a real register when not hardwired
    do_reset();
    vin = '{regwrite_m: 1'b1, memtoreg_e: 1'b1, regwrite_e: 1'b1, uses_rs_d: 1'b1, default: '0};
    @(negedge clk);
    chk("zr_fwd_hardwired", 32'(forward_a_e), 32'd0);
    chk("zr_fwd_plain", 32'(nz_fae), 32'd2);
    chk("zr_lwstall_plain", 32'(nz_sf), 32'd1);
    chk("zr_lwstall_hardwired", 32'(stall_f), 32'd0);

    // Load-use stall counting, one per cycle
    do_reset();
    vin = tbl[7].i;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1 chk($sformatf("lu_stall_cnt%0d", k), 32'(stall_cnt), 32'(k));
    end
    chk("lu_redirect_ignored", 32'(redirect_cnt), 32'd0);

    // Memory wait: three low cycles then ready
    do_reset();
    vin = '{memaccess_m: 1'b1, default: '0};
    for (int c = 0; c < 5; c++) begin
      if (c == 3) vin.dm_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("mw_state_c%0d", c), 32'(state), (c == 0 || c == 4) ? 32'd0 : 32'd1);
      chk($sformatf("mw_stall_c%0d", c), {28'd0, stall_f, stall_e, stall_m, bubble_w},
          (c < 3) ? 32'hF : 32'h0);
      @(posedge clk);
      #1;
    end
    chk("mw_memwait_cnt", 32'(memwait_cnt), 32'd3);
    chk("mw_no_timeout", 32'(mem_timeout), 32'd0);

    // Timeout into HALT on the fifth edge
    do_reset();
    vin = '{memaccess_m: 1'b1, default: '0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("to_state_c%0d", c), 32'(state), (c == 0) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
    end
    chk("to_halt_state", 32'(state), 32'd2);
    chk("to_timeout_flag", 32'(mem_timeout), 32'd1);
    vin = '{dm_ready: 1'b1, redirect_d: 1'b1, default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("halt_sticky_state", 32'(state), 32'd2);
    chk("halt_outputs", {25'd0, stall_f, stall_d, stall_e, stall_m, bubble_w, flush_d, flush_e},
        32'h7C);
    chk("halt_memwait_frozen", 32'(memwait_cnt), 32'd5);
    chk("halt_redirect_cnt", 32'(redirect_cnt), 32'd0);
    reset = 1'b1;
    #1;
    chk("halt_reset_state", 32'(state), 32'd0);
    chk("halt_reset_timeout", 32'(mem_timeout), 32'd0);

    // Counter saturation and clear priority
    do_reset();
    vin = '{redirect_d: 1'b1, default: '0};
    repeat (20) @(posedge clk);
    #1 chk("sat_redirect_cnt", 32'(redirect_cnt), 32'd15);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    chk("clr_over_inc", 32'(redirect_cnt), 32'd0);
    @(posedge clk);
    #1 chk("inc_after_clr", 32'(redirect_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
